// File: rtl/frame_pkg.sv
// +----------------------------------------------------------------------+
// | frame_pkg : shared types and constants for frame_stream_ctrl         |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package frame_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ARMED   = 4'd1,
    ST_CAPTURE = 4'd2,
    ST_HEADER  = 4'd3,
    ST_RD_ADDR = 4'd4,
    ST_RD_WAIT = 4'd5,
    ST_SEND0   = 4'd6,
    ST_SEND1   = 4'd7,
    ST_SEND2   = 4'd8,
    ST_DONE    = 4'd9
  } state_e;

  localparam int PIXEL_W   = 30;
  localparam int LANE0_LSB = 0;
  localparam int LANE1_LSB = 10;
  localparam int LANE2_LSB = 20;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/frame_stream_ctrl.sv
// +----------------------------------------------------------------------+
// | frame_stream_ctrl : capture one frame to RAM, stream it out as bytes |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module frame_stream_ctrl
  import frame_pkg::*;
#(
  parameter int         HEIGHT     = 100,
  parameter int         WIDTH      = 320,
  parameter int         HEADER_EN  = 1,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  localparam int        NUM_PIXELS = HEIGHT * WIDTH,
  localparam int        ADDR_W     = $clog2(NUM_PIXELS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               capture_req,
  input  logic               abort,
  input  logic               start_frame,
  input  logic               pixel_valid,
  output logic               buf_wr_en,
  output logic [ADDR_W-1:0]  buf_wr_addr,
  output logic [ADDR_W-1:0]  buf_rd_addr,
  input  logic [PIXEL_W-1:0] buf_rd_data,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               frame_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [PIXEL_W-1:0]   pixel_q, pixel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      pixel_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      pixel_q  <= pixel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    pixel_d    = pixel_q;
    buf_wr_en  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (capture_req) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (start_frame) begin
          state_d  = ST_CAPTURE;
          wr_cnt_d = '0;
        end
      end
      ST_CAPTURE: begin
        buf_wr_en = pixel_valid;
        if (pixel_valid) begin
          if (wr_cnt_q == LAST_ADDR) begin
            state_d  = (HEADER_EN != 0) ? ST_HEADER : ST_RD_ADDR;
            rd_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      ST_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (tx_ready) begin
          state_d  = ST_RD_ADDR;
          rd_cnt_d = '0;
        end
      end
      ST_RD_ADDR: state_d = ST_RD_WAIT;
      // RAM data for the address presented in RD_ADDR is valid here.
      ST_RD_WAIT: begin
        pixel_d = buf_rd_data;
        state_d = ST_SEND0;
      end
      ST_SEND0: begin
        tx_valid = 1'b1;
        tx_data  = pixel_q[LANE0_LSB +: 8];
        if (tx_ready) state_d = ST_SEND1;
      end
      ST_SEND1: begin
        tx_valid = 1'b1;
        tx_data  = pixel_q[LANE1_LSB +: 8];
        if (tx_ready) state_d = ST_SEND2;
      end
      ST_SEND2: begin
        tx_valid = 1'b1;
        tx_data  = pixel_q[LANE2_LSB +: 8];
        if (tx_ready) begin
          if (rd_cnt_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            state_d  = ST_RD_ADDR;
          end
        end
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) state_d = ST_IDLE;
  end

  assign busy        = (state_q != ST_IDLE);
  assign buf_wr_addr = wr_cnt_q;
  assign buf_rd_addr = rd_cnt_q;

  // Two spare bits per 10-bit lane are never transmitted.
  logic unused_pixel_bits;
  assign unused_pixel_bits = ^{pixel_q[29:28], pixel_q[19:18], pixel_q[9:8]};

endmodule

`default_nettype wire

// File: tb/tb_frame_stream_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_frame_stream_ctrl : self-checking bench for frame_stream_ctrl     |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_frame_stream_ctrl;

  localparam int N  = 6;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          capture_req = 1'b0;
  logic          abort = 1'b0;
  logic          start_frame = 1'b0;
  logic          pixel_valid = 1'b0;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [AW-1:0] buf_rd_addr;
  logic [29:0]   buf_rd_data = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic          busy;
  logic          frame_done;

  logic [29:0]   pixel_in = '0;

  frame_stream_ctrl #(
    .HEIGHT(2), .WIDTH(3), .HEADER_EN(1), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .capture_req(capture_req), .abort(abort),
    .start_frame(start_frame), .pixel_valid(pixel_valid),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // External frame RAM with one-cycle read latency.
  logic [29:0] mem [0:7];
  always @(posedge clk) buf_rd_data <= mem[buf_rd_addr];

  logic [AW-1:0] wr_addr_q[$];
  logic [7:0]    got_q[$];
  logic [29:0]   exp_pix[$];
  int            done_cnt = 0;

  logic          prev_pending = 1'b0;
  logic          prev_abort   = 1'b0;
  logic [7:0]    prev_data    = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending && !prev_abort) begin
        check("tx_valid_hold", {31'd0, tx_valid}, 32'd1);
        check("tx_data_hold", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (buf_wr_en) begin
        wr_addr_q.push_back(buf_wr_addr);
        mem[buf_wr_addr] = pixel_in;
      end
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (frame_done) done_cnt++;
      prev_pending = tx_valid && !tx_ready;
      prev_abort   = abort;
      prev_data    = tx_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    wr_addr_q.delete();
    got_q.delete();
    exp_pix.delete();
    done_cnt = 0;
  endtask

  task automatic start_capture();
    capture_req = 1'b1;
    start_frame = 1'b1;
    step();
    capture_req = 1'b0;
    start_frame = 1'b0;
    step();
    step();
    start_frame = 1'b1;
    step();
    start_frame = 1'b0;
  endtask

  // mode 0: valid every cycle, 1: every other cycle, 2: random
  task automatic capture_pixels(input int mode);
    int nv = 0;
    int cyc = 0;
    while (nv < N && cyc < 100) begin
      case (mode)
        0:       pixel_valid = 1'b1;
        1:       pixel_valid = cyc[0];
        default: pixel_valid = 1'($urandom_range(0, 1));
      endcase
      if (pixel_valid) begin
        pixel_in = 30'($urandom());
        exp_pix.push_back(pixel_in);
        nv++;
      end
      step();
      cyc++;
    end
    pixel_valid = 1'b0;
    check("capture_budget", nv, N);
  endtask

  // ready mode 0: random, 1: always high, 2: stall 10 cycles in SEND1
  task automatic stream(input int rmode, input bit noise);
    int cyc = 0;
    int hold = 0;
    logic [AW-1:0] ra = '0;
    while (done_cnt == 0 && cyc < 2000) begin
      case (rmode)
        0: tx_ready = 1'($urandom_range(0, 1));
        1: tx_ready = 1'b1;
        default: begin
          if (got_q.size() == 2 && hold < 10) begin
            if (hold == 0) ra = buf_rd_addr;
            tx_ready = 1'b0;
            hold++;
            if (hold == 10) check("stall_rd_addr", {29'd0, buf_rd_addr}, {29'd0, ra});
          end else begin
            tx_ready = 1'b1;
          end
        end
      endcase
      if (noise) begin
        capture_req = ($urandom_range(0, 3) == 0);
        start_frame = ($urandom_range(0, 3) == 0);
      end
      step();
      cyc++;
    end
    tx_ready    = 1'b0;
    capture_req = 1'b0;
    start_frame = 1'b0;
    if (done_cnt == 0) check("stream_timeout", 32'd0, 32'd1);
  endtask

  task automatic verify_frame(input string tag);
    logic [7:0]  exp_b[$];
    logic [29:0] p;
    exp_b.push_back(8'hA5);
    foreach (exp_pix[i]) begin
      p = exp_pix[i];
      exp_b.push_back(p[7:0]);
      exp_b.push_back(p[17:10]);
      exp_b.push_back(p[27:20]);
    end
    check({tag, "_wr_count"}, wr_addr_q.size(), N);
    foreach (wr_addr_q[i]) check({tag, "_wr_addr"}, {29'd0, wr_addr_q[i]}, i);
    check({tag, "_byte_count"}, got_q.size(), exp_b.size());
    for (int i = 0; i < got_q.size() && i < exp_b.size(); i++)
      check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_b[i]});
    check({tag, "_done_pulses"}, done_cnt, 1);
    repeat (4) step();
    check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_no_extra_wr"}, wr_addr_q.size(), N);
  endtask

  typedef struct {
    bit         req, sf, pv, rdy;
    bit         e_busy, e_wr;
    logic [2:0] e_wa;
    bit         e_tv;
    logic [7:0] e_td;
  } vec_t;

  function automatic vec_t row(bit req, bit sf, bit pv, bit rdy, bit eb,
                               bit ew, logic [2:0] ewa, bit etv, logic [7:0] etd);
    vec_t v;
    v.req = req; v.sf = sf; v.pv = pv; v.rdy = rdy;
    v.e_busy = eb; v.e_wr = ew; v.e_wa = ewa; v.e_tv = etv; v.e_td = etd;
    return v;
  endfunction

  vec_t tbl [0:20];

  initial begin
    int nv;

    //            req sf pv rdy busy wr wa tv  td
    tbl[0]  = row(0, 0, 0, 0,  0,   0, 0, 0, 8'h00);
    tbl[1]  = row(0, 1, 0, 0,  0,   0, 0, 0, 8'h00);
    tbl[2]  = row(1, 1, 0, 0,  0,   0, 0, 0, 8'h00);
    tbl[3]  = row(0, 0, 0, 0,  1,   0, 0, 0, 8'h00);
    tbl[4]  = row(0, 0, 1, 0,  1,   0, 0, 0, 8'h00);
    tbl[5]  = row(0, 1, 0, 0,  1,   0, 0, 0, 8'h00);
    tbl[6]  = row(0, 0, 1, 0,  1,   1, 0, 0, 8'h00);
    tbl[7]  = row(0, 1, 0, 0,  1,   0, 0, 0, 8'h00);
    tbl[8]  = row(0, 0, 1, 0,  1,   1, 1, 0, 8'h00);
    tbl[9]  = row(0, 0, 0, 0,  1,   0, 0, 0, 8'h00);
    tbl[10] = row(0, 0, 1, 0,  1,   1, 2, 0, 8'h00);
    tbl[11] = row(1, 0, 1, 0,  1,   1, 3, 0, 8'h00);
    tbl[12] = row(0, 0, 0, 0,  1,   0, 0, 0, 8'h00);
    tbl[13] = row(0, 0, 1, 0,  1,   1, 4, 0, 8'h00);
    tbl[14] = row(0, 0, 1, 0,  1,   1, 5, 0, 8'h00);
    tbl[15] = row(0, 0, 0, 0,  1,   0, 0, 1, 8'hA5);
    tbl[16] = row(0, 0, 0, 0,  1,   0, 0, 1, 8'hA5);
    tbl[17] = row(0, 0, 0, 1,  1,   0, 0, 1, 8'hA5);
    tbl[18] = row(0, 0, 0, 1,  1,   0, 0, 0, 8'h00);
    tbl[19] = row(0, 0, 0, 1,  1,   0, 0, 0, 8'h00);
    tbl[20] = row(0, 0, 0, 1,  1,   0, 0, 1, 8'h01);

    repeat (2) step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_wr_en", {31'd0, buf_wr_en}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_addrs", {26'd0, buf_wr_addr, buf_rd_addr}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    rst_n = 1'b1;
    step();

    // Table run: startup, toggled pixel_valid, header stall, first byte.
    clear();
    nv = 0;
    for (int i = 0; i <= 20; i++) begin
      capture_req = tbl[i].req;
      start_frame = tbl[i].sf;
      pixel_valid = tbl[i].pv;
      tx_ready    = tbl[i].rdy;
      if (tbl[i].e_wr) begin
        pixel_in = 30'd1 + 30'(nv);
        exp_pix.push_back(pixel_in);
        nv++;
      end else begin
        pixel_in = 30'h3FFF_FFFF;
      end
      #2;
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
      check($sformatf("vec%0d_wr_en", i), {31'd0, buf_wr_en}, {31'd0, tbl[i].e_wr});
      if (tbl[i].e_wr)
        check($sformatf("vec%0d_wr_addr", i), {29'd0, buf_wr_addr}, {29'd0, tbl[i].e_wa});
      check($sformatf("vec%0d_tx_valid", i), {31'd0, tx_valid}, {31'd0, tbl[i].e_tv});
      if (tbl[i].e_tv)
        check($sformatf("vec%0d_tx_data", i), {24'd0, tx_data}, {24'd0, tbl[i].e_td});
      step();
    end
    capture_req = 1'b0; start_frame = 1'b0; pixel_valid = 1'b0;
    stream(1, 0);
    verify_frame("tbl");

    // Continuous pixels, request/start noise while streaming.
    clear(); start_capture(); capture_pixels(0); stream(1, 1); verify_frame("cont");

    // Ten-cycle stall in SEND1.
    clear(); start_capture(); capture_pixels(1); stream(2, 0); verify_frame("stall");

    // Abort during capture at address 3.
    clear(); start_capture();
    for (int i = 0; i < 3; i++) begin
      pixel_valid = 1'b1; pixel_in = 30'($urandom()); step();
    end
    pixel_valid = 1'b0;
    #1 check("abort_cap_addr", {29'd0, buf_wr_addr}, 32'd3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    pixel_valid = 1'b1;
    #1;
    check("abort_cap_busy", {31'd0, busy}, 32'd0);
    check("abort_cap_wr_en", {31'd0, buf_wr_en}, 32'd0);
    step();
    pixel_valid = 1'b0;
    check("abort_cap_writes", wr_addr_q.size(), 3);

    // Abort while SEND2 of pixel 0 is pending.
    clear(); start_capture(); capture_pixels(0);
    for (int c = 0; c < 100 && got_q.size() < 3; c++) begin
      tx_ready = 1'b1; step();
    end
    tx_ready = 1'b0;
    #1 check("send2_pending", {31'd0, tx_valid}, 32'd1);
    check("send2_data", {24'd0, tx_data}, {24'd0, exp_pix[0][27:20]});
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (5) step();
    check("abort_no_done", done_cnt, 0);

    clear(); start_capture(); capture_pixels(2); stream(0, 1); verify_frame("rand");

    // Asynchronous reset in the middle of streaming.
    clear(); start_capture(); capture_pixels(0);
    tx_ready = 1'b1;
    repeat (7) step();
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("arst_tx_data", {24'd0, tx_data}, 32'd0);
    check("arst_addrs", {26'd0, buf_wr_addr, buf_rd_addr}, 32'd0);
    check("arst_done", {31'd0, frame_done}, 32'd0);
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    check("arst_idle", {31'd0, busy}, 32'd0);

    clear(); start_capture(); capture_pixels(2); stream(0, 0); verify_frame("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
